// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the sequential ALU.
package alu_pkg;
  localparam int WORD_SIZE = 32;
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_DIVU = 4'b1011,
    OP_REMU = 4'b1100
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;
  function automatic logic is_multicycle(alu_op_e op);
    return op inside {OP_MUL, OP_DIVU, OP_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: WIDTH-step shift-add multiplier and restoring unsigned divider.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  alu_op_e op_q;
  logic busy_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [WIDTH:0] rem_sh, diff;
  // MUL: acc += x when y[0]; x shifts left, y right. DIV: acc is the partial remainder, x the dividend/quotient, y the divisor.
  always_comb begin
    rem_sh = {acc_q, x_q[WIDTH-1]};
    diff = rem_sh - {1'b0, y_q};
    acc_d = op_q == OP_MUL ? (y_q[0] ? acc_q + x_q : acc_q) : (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]);
    x_d = op_q == OP_MUL ? x_q << 1 : {x_q[WIDTH-2:0], ~diff[WIDTH]};
    y_d = op_q == OP_MUL ? y_q >> 1 : y_q;
  end
  assign busy_o = busy_q;
  assign done_o = busy_q && cnt_q == CW'(WIDTH - 1);
  assign result_o = op_q == OP_DIVU ? x_d : acc_d;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      op_q <= OP_ADD;
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q <= '0;
      op_q <= op_i;
      acc_q <= '0;
      x_q <= a_i;
      y_q <= b_i;
    end else if (busy_q) begin
      busy_q <= !done_o;
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/arith_logic_unit_seq.sv
// arith_logic_unit_seq: multi-cycle ALU with valid/ready handshake and registered result/flags.
module arith_logic_unit_seq import alu_pkg::*; #(
  parameter int WIDTH = WORD_SIZE,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [3:0]       control_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  alu_state_e state_q;
  alu_op_e op;
  logic [WIDTH-1:0] b_eff, res_d, md_res, out_q;
  logic [WIDTH:0] sum;
  logic [SHAMT_W-1:0] shamt;
  logic carry_d, ovf_d, md_busy, md_done, start, zero_q, carry_q, ovf_q;
  assign op = alu_op_e'(control_i);
  assign shamt = in2_i[SHAMT_W-1:0];
  assign start = state_q == IDLE && in_valid_i && is_multicycle(op);
  // SUB is In1 + ~In2 + 1, so the carry-out is the inverted borrow.
  always_comb begin
    b_eff = op == OP_SUB ? ~in2_i : in2_i;
    sum = {1'b0, in1_i} + {1'b0, b_eff} + (WIDTH+1)'(op == OP_SUB);
    carry_d = (op == OP_ADD || op == OP_SUB) && sum[WIDTH];
    ovf_d = (op == OP_ADD || op == OP_SUB) && in1_i[WIDTH-1] == b_eff[WIDTH-1] && sum[WIDTH-1] != in1_i[WIDTH-1];
    case (op)
      OP_ADD, OP_SUB: res_d = sum[WIDTH-1:0];
      OP_AND:  res_d = in1_i & in2_i;
      OP_OR:   res_d = in1_i | in2_i;
      OP_XOR:  res_d = in1_i ^ in2_i;
      OP_SLL:  res_d = in1_i << shamt;
      OP_SRL:  res_d = in1_i >> shamt;
      OP_SRA:  res_d = WIDTH'($signed(in1_i) >>> shamt);
      OP_SLT:  res_d = WIDTH'($signed(in1_i) < $signed(in2_i));
      OP_SLTU: res_d = WIDTH'(in1_i < in2_i);
      default: res_d = '0;
    endcase
  end
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start),
    .op_i     (op),
    .a_i      (in1_i),
    .b_i      (in2_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      out_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          if (is_multicycle(op)) state_q <= BUSY;
          else begin
            state_q <= DONE;
            out_q <= res_d;
            zero_q <= res_d == '0;
            carry_q <= carry_d;
            ovf_q <= ovf_d;
          end
        end
        BUSY: if (md_done) begin
          state_q <= DONE;
          out_q <= md_res;
          zero_q <= md_res == '0;
          carry_q <= 1'b0;
          ovf_q <= 1'b0;
        end else if (!md_busy) state_q <= IDLE;
        DONE: if (out_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign out_o = out_q;
  assign zero_o = zero_q;
  assign carry_o = carry_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_arith_logic_unit_seq.sv
// tb_arith_logic_unit_seq: transaction-level model checks plus directed literal cases.
module tb_arith_logic_unit_seq;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] r; logic c; logic v;} res_t;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [3:0] control = '0;
  logic in_ready, zero, carry, ovf, out_valid;
  logic [W-1:0] out;
  int tests = 0, fails = 0, n = 0, due = 0;
  logic pend = 1'b0, rchk = 1'b1;
  res_t exp_q;

  always #5 clk = ~clk;

  arith_logic_unit_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .in1_i(in1), .in2_i(in2), .control_i(control),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_o(out), .zero_o(zero),
    .carry_o(carry), .overflow_o(ovf), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    longint sa, sb, s;
    logic [63:0] p;
    int sh;
    m = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin
        p = {32'b0, a} + {32'b0, b};
        s = sa + sb;
        m.r = p[W-1:0]; m.c = p[W]; m.v = s > MAXS || s < MINS;
      end
      4'd1: begin
        p = {32'b0, a} - {32'b0, b};
        s = sa - sb;
        m.r = p[W-1:0]; m.c = a >= b; m.v = s > MAXS || s < MINS;
      end
      4'd2: m.r = a & b;
      4'd3: m.r = a | b;
      4'd4: m.r = a ^ b;
      4'd5: m.r = a << sh;
      4'd6: m.r = a >> sh;
      4'd7: m.r = W'($signed(a) >>> sh);
      4'd8: m.r = W'(sa < sb);
      4'd9: m.r = W'(a < b);
      4'd10: begin p = {32'b0, a} * {32'b0, b}; m.r = p[W-1:0]; end
      4'd11: m.r = b == 0 ? '1 : a / b;
      4'd12: m.r = b == 0 ? a : a % b;
      default: m.r = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_mc(input logic [3:0] op);
    return op == 4'd10 || op == 4'd11 || op == 4'd12;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, n);
    end
  endtask

  // Transaction-level reference: one op in flight, result due a fixed latency after accept.
  always @(negedge clk) begin
    if (rchk) begin
      check("rst_out", out, 0);
      check("rst_zero", zero, 0);
      check("rst_carry", carry, 0);
      check("rst_ovf", ovf, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
    end else if (pend) begin
      check("busy_ready", in_ready, 0);
      check("out_valid", out_valid, n >= due);
      if (n >= due) begin
        check("out", out, exp_q.r);
        check("zero", zero, exp_q.r == 0);
        check("carry", carry, exp_q.c);
        check("ovf", ovf, exp_q.v);
      end
    end else begin
      check("idle_ready", in_ready, 1);
      check("idle_valid", out_valid, 0);
    end
    if (!rst_n) begin
      pend = 1'b0;
      rchk = 1'b1;
    end else begin
      rchk = 1'b0;
      if (pend) begin
        if (n >= due && out_ready) pend = 1'b0;
      end else if (in_valid) begin
        pend = 1'b1;
        exp_q = model(control, in1, in2);
        due = n + (is_mc(control) ? W + 1 : 1);
      end
    end
    n++;
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    check("issue_ready_wait", t < 200, 1);
    control = op; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic ev);
    res_t m;
    int t = 0;
    m = model(op, a, b);
    check({name, "_model_r"}, m.r, er);
    check({name, "_model_c"}, m.c, ec);
    check({name, "_model_v"}, m.v, ev);
    issue(op, a, b);
    while (!out_valid && t < 200) begin
      check({name, "_stall_ready"}, in_ready, 0);
      @(posedge clk); #1; t++;
    end
    check({name, "_latency"}, t, is_mc(op) ? W : 0);
    check({name, "_out"}, out, er);
    check({name, "_zero"}, zero, er == 0);
    check({name, "_carry"}, carry, ec);
    check({name, "_ovf"}, ovf, ev);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_lit("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_lit("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_lit("sra", 4'd7, 32'h8000_0010, 32'h24, 32'hF800_0001, 1'b0, 1'b0);
    run_lit("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_lit("mul", 4'd10, 32'd12345, 32'd6789, 32'd83810205, 1'b0, 1'b0);
    run_lit("divu", 4'd11, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    run_lit("remu", 4'd12, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    run_lit("divu0", 4'd11, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_lit("remu0", 4'd12, 32'd55, 32'd0, 32'd55, 1'b0, 1'b0);
    run_lit("undef", 4'b1110, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b0);
    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    issue(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    in_valid = 1'b1; control = 4'd0; in1 = 32'd9; in2 = 32'd9;
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_out", out, 32'hFF00_FF00);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    // Reset during MUL: the partial product must never surface.
    issue(4'd10, 32'd12345, 32'd6789);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_ready", in_ready, 1);
    rst_n = 1'b1;
    run_lit("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    // Random traffic, including stalls, junk in_valid while busy and occasional resets.
    repeat (4000) begin
      rst_n = $urandom_range(0, 299) != 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      control = 4'($urandom_range(0, 15));
      in1 = rnd_word();
      in2 = rnd_word();
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 5) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/arith_logic_unit_seq.md
Name: arith_logic_unit_seq

Overview:
- Parametrised, multi-cycle successor to the combinational ALU.
- Executes the full integer op set: add/sub, logic, shifts, compares, iterative multiply, unsigned divide and remainder.
- Valid/ready handshake on input and output, so the execute stage can stall on long ops.
- Result is registered, with Zero/Carry/Overflow flags.

Parameters:
- WIDTH, default `WORD_SIZE (32): operand and result width; legal values are 8..64 and powers of two.
- SHAMT_W, default $clog2(WIDTH): shift-amount bits taken from In2; derived, never overridden.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- In1  input  WIDTH  operand A
- In2  input  WIDTH  operand B
- Control  input  4  opcode, sampled on accept
- In_valid  input  1  operands and Control valid
- In_ready  output  1  unit can accept
- Out  output  WIDTH  result
- Zero  output  1  Out == 0
- Carry  output  1  carry-out of ADD; NOT borrow of SUB; else 0
- Overflow  output  1  signed overflow of ADD/SUB; else 0
- Out_valid  output  1  result valid
- Out_ready  input  1  consumer takes result

Behaviour:
- Opcodes (Control):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT (signed), 1001 SLTU
  - 1010 MUL (low WIDTH bits of product), 1011 DIVU, 1100 REMU
  - 1101..1111 undefined: Out = 0, flags = 0, latency 1.
- Shifts use In2[SHAMT_W-1:0] only; upper bits are ignored.
- SLT/SLTU: Out = {WIDTH-1 zeros, result bit}.
- Division by zero: DIVU returns all ones; REMU returns In1. No exception.
- FSM states IDLE, BUSY, DONE:
  - IDLE: In_ready=1. When In_valid=1, latch operands and opcode.
    - Single-cycle op: compute, register result → DONE.
    - MUL/DIVU/REMU: → BUSY, iteration counter = 0.
  - BUSY: In_ready=0. One shift-add (MUL) or one restoring-division step (DIV/REM) per cycle. After WIDTH steps → DONE.
  - DONE: Out_valid=1; Out and flags stable. When Out_ready=1, go to IDLE; Out_valid falls the next cycle.
- Latency: accept at edge N.
  - Single-cycle ops: Out_valid at N+1.
  - Iterative ops: Out_valid at N+WIDTH+1.
- Throughput: at most one op per two cycles. In_ready is 0 in DONE, so accept and drain never happen on the same edge.
- Out_ready is ignored outside DONE. In_valid is ignored outside IDLE. No combinational path from inputs to outputs.
- Zero is computed from the final registered Out for every opcode.
- Reset (Rst_n=0 at an edge), including mid-BUSY or in DONE:
  - state → IDLE; Out=0, Zero=0, Carry=0, Overflow=0, Out_valid=0, counter=0.
  - In_ready=1 from the first edge with Rst_n=1.
  - A partially computed op is discarded; nothing is emitted for it.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e with the opcodes above.
  - typedef enum logic [1:0] alu_state_e {IDLE, BUSY, DONE}.
  - Function is_multicycle(alu_op_e).
- Sub-module alu_muldiv_iter:
  - Ports: Start, Op, A, B, Busy, Done, Result.
  - Holds the accumulator, shifted operands and WIDTH-step counter.
  - Top level keeps the FSM, handshake, single-cycle datapath and flags.

Test Plan:
- ADD, In1=32'hFFFF_FFFF, In2=1, Out_ready=1 → one cycle later Out=0, Zero=1, Carry=1, Overflow=0, Out_valid for 1 cycle.
- SUB, In1=32'h8000_0000, In2=1 → Out=32'h7FFF_FFFF, Overflow=1, Carry=1. SRA, In1=32'h8000_0010, In2=32'h24 (shamt 4) → Out=32'hF800_0001.
- MUL, In1=12345, In2=6789 → Out=83810205, Out_valid exactly 33 cycles after accept, In_ready=0 throughout. DIVU, 100/7 → 14; REMU, 100/7 → 2.
- DIVU, In1=55, In2=0 → 32'hFFFF_FFFF; REMU, In1=55, In2=0 → 55; Zero=0 for both.
- Backpressure: complete an XOR with Out_ready=0 for 5 cycles → Out, flags and Out_valid held stable, In_ready=0 despite In_valid=1. Raise Out_ready → next-cycle In_ready=1.
- Reset mid-MUL at step 10 → outputs cleared next edge. Release reset and issue ADD 2+3 → Out=5; no stale MUL result ever appears. Opcode 1110 → Out=0, flags 0, latency 1.
